// File: rtl/pwm_duty_ramp.sv
// Duty-cycle soft-start/soft-stop ramp feeding the PWM generator.
// Steps dutyCycle toward a commanded target every STEP_DIV cycles and strobes start on each update.
module pwm_duty_ramp #(
    parameter int WORD_LENGTH      = 8,
    parameter int WORD_LENGTH_FREQ = 2,
    parameter int STEP_DIV         = 1000,
    parameter int TIMER_W          = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        go,
    input  logic                        abort,
    input  logic [WORD_LENGTH-1:0]      target_duty,
    input  logic [WORD_LENGTH_FREQ-1:0] freq_sel,
    input  logic [WORD_LENGTH-1:0]      step_size,
    output logic [WORD_LENGTH-1:0]      dutyCycle,
    output logic [WORD_LENGTH_FREQ-1:0] frequency,
    output logic                        start,
    output logic                        busy,
    output logic                        done
);

    localparam logic [TIMER_W-1:0] TMAX = TIMER_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

    state_t                      state, state_n;
    logic [WORD_LENGTH-1:0]      tgt, tgt_n, step, step_n, duty_n, step_in, stepped;
    logic [WORD_LENGTH_FREQ-1:0] freq_n;
    logic [TIMER_W-1:0]          timer, timer_n, timer_inc;
    logic                        start_n, done_n, busy_n, wrap;
    logic [WORD_LENGTH:0]        up_sum, dn_lim;

    assign step_in   = (step_size == '0) ? WORD_LENGTH'(1) : step_size;
    assign wrap      = (timer == TMAX);
    assign timer_inc = wrap ? '0 : timer + TIMER_W'(1);

    // Saturating step computed one bit wider so neither direction can wrap past the target.
    assign up_sum = {1'b0, dutyCycle} + {1'b0, step};
    assign dn_lim = {1'b0, tgt} + {1'b0, step};

    always_comb begin
        stepped = tgt;
        if (dutyCycle < tgt) begin
            if (up_sum < {1'b0, tgt})
                stepped = up_sum[WORD_LENGTH-1:0];
        end else begin
            if ({1'b0, dutyCycle} > dn_lim)
                stepped = dutyCycle - step;
        end
    end

    always_comb begin
        state_n = state;
        duty_n  = dutyCycle;
        freq_n  = frequency;
        tgt_n   = tgt;
        step_n  = step;
        timer_n = timer;
        start_n = 1'b0;
        done_n  = 1'b0;
        busy_n  = busy;
        if (abort) begin
            state_n = IDLE;
            duty_n  = '0;
            timer_n = '0;
            busy_n  = 1'b0;
            start_n = (dutyCycle != '0);
        end else if (go) begin
            tgt_n   = target_duty;
            step_n  = step_in;
            freq_n  = freq_sel;
            start_n = 1'b1;
            // A retarget mid-ramp keeps the step cadence instead of restarting it.
            timer_n = (state == RAMP) ? timer_inc : '0;
            if (target_duty == dutyCycle) begin
                state_n = HOLD;
                done_n  = 1'b1;
                busy_n  = 1'b0;
            end else begin
                state_n = RAMP;
                busy_n  = 1'b1;
            end
        end else if (state == RAMP) begin
            timer_n = timer_inc;
            if (wrap) begin
                duty_n  = stepped;
                start_n = 1'b1;
                if (stepped == tgt) begin
                    state_n = HOLD;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dutyCycle <= '0;
            frequency <= '0;
            tgt       <= '0;
            step      <= '0;
            timer     <= '0;
            start     <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            dutyCycle <= duty_n;
            frequency <= freq_n;
            tgt       <= tgt_n;
            step      <= step_n;
            timer     <= timer_n;
            start     <= start_n;
            done      <= done_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: per-cycle comparison against an arithmetic model
// plus literal checkpoints along each scenario.
module tb_pwm_duty_ramp;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0, abort = 1'b0;
    logic [7:0] target_duty = '0, step_size = '0;
    logic [1:0] freq_sel = '0;
    logic [7:0] dutyCycle;
    logic [1:0] frequency;
    logic       start, busy, done;

    int checks = 0, errors = 0, starts = 0;

    int m_duty, m_tgt, m_step, m_freq, m_cnt;
    bit m_start, m_done, m_busy, m_ramp;

    pwm_duty_ramp #(.WORD_LENGTH(8), .WORD_LENGTH_FREQ(2), .STEP_DIV(SD), .TIMER_W(3)) dut (
        .clk(clk), .reset(reset), .go(go), .abort(abort),
        .target_duty(target_duty), .freq_sel(freq_sel), .step_size(step_size),
        .dutyCycle(dutyCycle), .frequency(frequency), .start(start),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Model: m_cnt counts cycles since the ramp cadence began; every SD-th one moves duty.
    always @(posedge clk or negedge reset) begin
        int d, t, s, f, c;
        bit st, dn, rp;
        if (!reset) begin
            m_duty <= 0; m_tgt <= 0; m_step <= 0; m_freq <= 0; m_cnt <= 0;
            m_start <= 0; m_done <= 0; m_busy <= 0; m_ramp <= 0;
        end else begin
            d = m_duty; t = m_tgt; s = m_step; f = m_freq; c = m_cnt;
            rp = m_ramp; st = 0; dn = 0;
            if (abort) begin
                st = (d != 0); d = 0; rp = 0; c = 0;
            end else if (go) begin
                t = target_duty;
                s = (step_size == 0) ? 1 : int'(step_size);
                f = freq_sel;
                st = 1;
                c = rp ? (c + 1) % SD : 0;
                if (t == d) begin rp = 0; dn = 1; end
                else rp = 1;
            end else if (rp) begin
                c = c + 1;
                if (c == SD) begin
                    c = 0; st = 1;
                    if (d < t) d = (d + s < t) ? d + s : t;
                    else       d = (d - s > t) ? d - s : t;
                    if (d == t) begin rp = 0; dn = 1; end
                end
            end
            m_duty <= d; m_tgt <= t; m_step <= s; m_freq <= f; m_cnt <= c;
            m_start <= st; m_done <= dn; m_ramp <= rp; m_busy <= rp;
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({dutyCycle, frequency, start, done, busy} !==
            {8'(m_duty), 2'(m_freq), m_start, m_done, m_busy}) begin
            errors++;
            $display("FAIL cycle_compare t=%0t got duty=%0d freq=%0d start=%0b done=%0b busy=%0b want duty=%0d freq=%0d start=%0b done=%0b busy=%0b",
                     $time, dutyCycle, frequency, start, done, busy,
                     m_duty, m_freq, m_start, m_done, m_busy);
        end
        if (start === 1'b1) starts++;
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_go(int t, int f, int s);
        target_duty = 8'(t); freq_sel = 2'(f); step_size = 8'(s);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic do_abort(bit with_go);
        abort = 1'b1; go = with_go;
        if (with_go) begin target_duty = 8'd7; freq_sel = 2'd3; step_size = 8'd1; end
        @(negedge clk);
        abort = 1'b0; go = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_timeout", int'(done), 1);
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        @(negedge clk);
        starts = 0;
        cyc(20);
        chk("idle_duty", dutyCycle, 0);
        chk("idle_busy", busy, 0);
        chk("idle_starts", starts, 0);

        // Ramp up with saturation at the target.
        starts = 0;
        do_go(10, 2, 4);
        chk("up_start", start, 1);
        chk("up_freq", frequency, 2);
        chk("up_duty0", dutyCycle, 0);
        chk("up_busy", busy, 1);
        cyc(4); chk("up_duty4", dutyCycle, 4);
        cyc(4); chk("up_duty8", dutyCycle, 8);
        cyc(4); chk("up_duty10", dutyCycle, 10);
        chk("up_done", done, 1);
        chk("up_busy_fall", busy, 0);
        cyc(1); chk("up_starts", starts, 4);

        // Ramp down from HOLD.
        do_go(0, 1, 3);
        chk("dn_duty10", dutyCycle, 10);
        cyc(4); chk("dn_duty7", dutyCycle, 7);
        cyc(12); chk("dn_duty0", dutyCycle, 0);
        chk("dn_done", done, 1);

        // Zero step behaves as one.
        do_go(2, 1, 0);
        cyc(4); chk("s0_duty1", dutyCycle, 1);
        cyc(4); chk("s0_duty2", dutyCycle, 2);
        chk("s0_done", done, 1);

        // Target equal to current duty.
        do_go(2, 3, 5);
        chk("eq_start", start, 1);
        chk("eq_done", done, 1);
        chk("eq_busy", busy, 0);
        chk("eq_freq", frequency, 3);

        do_abort(1'b0);
        chk("ab2_duty", dutyCycle, 0);
        chk("ab2_start", start, 1);

        // Retarget mid-ramp keeps the cadence.
        do_go(200, 0, 10);
        cyc(12); chk("rt_duty30", dutyCycle, 30);
        do_go(20, 1, 10);
        chk("rt_hold30", dutyCycle, 30);
        chk("rt_start", start, 1);
        cyc(3); chk("rt_duty20", dutyCycle, 20);
        chk("rt_done", done, 1);
        chk("rt_busy", busy, 0);

        // Top-of-range saturation without wrap.
        do_go(250, 0, 230);
        cyc(4); chk("sat_duty250", dutyCycle, 250);
        do_go(255, 0, 255);
        wait_done(20);
        chk("sat_duty255", dutyCycle, 255);

        // Abort mid-ramp.
        do_go(0, 0, 215);
        cyc(4); chk("ab_duty40", dutyCycle, 40);
        do_abort(1'b0);
        chk("ab_duty0", dutyCycle, 0);
        chk("ab_start", start, 1);
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        cyc(2);

        // go and abort together: abort wins, new freq ignored.
        do_go(100, 2, 50);
        cyc(4); chk("col_duty50", dutyCycle, 50);
        do_abort(1'b1);
        chk("col_duty0", dutyCycle, 0);
        chk("col_freq", frequency, 2);
        chk("col_busy", busy, 0);
        cyc(8); chk("col_idle", dutyCycle, 0);

        // Asynchronous reset mid-ramp.
        do_go(100, 1, 10);
        cyc(8); chk("rst_duty20", dutyCycle, 20);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("rst_duty", dutyCycle, 0);
        chk("rst_busy", busy, 0);
        chk("rst_freq", frequency, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(negedge clk);
        starts = 0;
        cyc(10);
        chk("rst_quiet", starts, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
Upstream control stage for the PWM generator. Soft-starts and soft-stops the PWM by stepping the duty-cycle word from its current value toward a commanded target at a programmed rate. It also latches the frequency select and pulses the PWM start input on every update. Its dutyCycle, frequency and start outputs connect directly to the PWM block's inputs of the same names.

Parameters:
WORD_LENGTH, 8, width of the duty-cycle word and of the step size.
WORD_LENGTH_FREQ, 2, width of the frequency select (4 clock-generator choices).
STEP_DIV, 1000, clock cycles between successive duty steps (>=2).
TIMER_W, 10, width of the step timer; must satisfy 2^TIMER_W >= STEP_DIV.

Ports:
clk  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-low reset.
go  in  1  one-cycle command strobe: accept new target/freq/step.
abort  in  1  one-cycle strobe: immediate stop, duty forced to 0.
target_duty  in  WORD_LENGTH  commanded final duty cycle.
freq_sel  in  WORD_LENGTH_FREQ  commanded frequency select.
step_size  in  WORD_LENGTH  duty increment/decrement per step; 0 is treated as 1.
dutyCycle  out  WORD_LENGTH  registered duty word to PWM.
frequency  out  WORD_LENGTH_FREQ  registered frequency select to PWM.
start  out  1  one-cycle pulse whenever dutyCycle/frequency is updated.
busy  out  1  high while ramping.
done  out  1  one-cycle pulse when dutyCycle reaches target.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; dutyCycle=0, frequency=0, start=0, busy=0, done=0; timer=0; latched target/step=0.
- Registered outputs: every output is registered. A command sampled at edge N is visible at edge N+1.
- States: IDLE, RAMP, HOLD.
- go in IDLE or HOLD:
  - Latch target_duty, freq_sel, and step_size (0 becomes 1).
  - Load frequency from freq_sel and pulse start for one cycle.
  - Clear the timer.
  - If target != dutyCycle: go to RAMP, busy=1.
  - Else: go to HOLD and pulse done on the same cycle as start.
- RAMP:
  - Timer counts 0..STEP_DIV-1, then wraps.
  - On wrap, apply one step:
    - up: dutyCycle = min(dutyCycle+step, target), computed at WORD_LENGTH+1 bits, no overflow wrap.
    - down: dutyCycle = max(dutyCycle-step, target), no underflow wrap.
  - Pulse start on every step.
  - The first step lands STEP_DIV cycles after the go edge.
  - On the step that makes dutyCycle == target: go to HOLD, busy=0, pulse done on the same cycle as that start.
- go during RAMP (retarget):
  - Latch the new target, freq and step; frequency updates and start pulses.
  - dutyCycle keeps its current value and the timer keeps running, not cleared.
  - Direction is re-evaluated against the new target.
  - If the new target equals the current duty: go to HOLD with done.
- HOLD: outputs stable, no start pulses. Only go or abort leaves HOLD.
- abort (any state): dutyCycle=0, state=IDLE, busy=0, timer=0.
  - Pulse start only if dutyCycle was nonzero.
  - No done pulse. frequency is retained.
- Simultaneous go and abort: abort wins, go is ignored.
- start and done never exceed one cycle. Back-to-back go strobes each produce their own start pulse.
- Reset asserted mid-ramp: immediate return to reset values. No further pulses until a new go.

Test Plan:
(STEP_DIV=4 in all scenarios.)
- Reset then idle: hold reset=0 for 3 cycles, release, no strobes for 20 cycles -> all outputs 0, start never high.
- Ramp up with saturation: go with target=10, step=4, freq=2 -> start at go+1 (freq=2, duty=0), then duty 4, 8, 10 at go+4, +8, +12. done and busy fall coincide with duty=10. Total 4 start pulses.
- Ramp down from HOLD at 10: go with target=0, step=3 -> duty 7, 4, 1, 0 on successive 4-cycle steps, done with the final 0.
- Retarget mid-ramp: ramp 0->200 step=10, reach duty=30, go with target=20 -> duty then 20 on the next timer wrap, not restarted. HOLD with done.
- Edge cases: step=0 and target=2 -> duty 1, 2. go with target equal to the current duty -> single cycle with start=1 and done=1, busy stays 0. step=255 from 250 toward 255 -> duty 255, no wrap.
- Abort and collision: abort at duty=40 mid-ramp -> next cycle duty=0, start=1, busy=0, no done. go and abort on the same cycle -> IDLE, duty=0. reset=0 mid-ramp -> outputs 0 asynchronously.
